// File: rtl/calc_accum_core.sv
// Accumulator calculator core: single-cycle add/sub/accumulate plus iterative
// shift-add signed multiply and multiply-accumulate, with sticky overflow.
module calc_accum_core #(
    parameter int WIDTH    = 32,
    parameter int IMM_W    = 14,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [2+2*IMM_W:0]   instr,
    output logic [WIDTH-1:0]     result,
    output logic                 result_valid,
    output logic                 overflow,
    output logic                 busy
);

    localparam int CNT_W = $clog2(IMM_W + 1);

    localparam logic [2:0] F_ADD    = 3'b000;
    localparam logic [2:0] F_SUB    = 3'b001;
    localparam logic [2:0] F_ADDACC = 3'b010;
    localparam logic [2:0] F_SUBACC = 3'b011;
    localparam logic [2:0] F_MUL    = 3'b100;
    localparam logic [2:0] F_MAC    = 3'b101;
    localparam logic [2:0] F_CLRF   = 3'b110;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, MUL} state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [WIDTH-1:0]   r_acc;
    logic               r_ovf;
    logic               r_valid;
    logic [WIDTH-1:0]   r_aSh;
    logic [IMM_W-1:0]   r_b;
    logic               r_isMac;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_p;

    logic [2:0]         w_funct;
    logic [IMM_W-1:0]   w_immA;
    logic [IMM_W-1:0]   w_immB;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic               w_accept;
    logic               w_lastBit;
    logic [WIDTH-1:0]   w_pStep;
    logic [WIDTH-1:0]   w_pNext;
    logic [WIDTH-1:0]   w_x;
    logic [WIDTH-1:0]   w_y;
    logic               w_sub;
    logic [WIDTH-1:0]   w_sum;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_final;

    assign w_funct  = instr[2+2*IMM_W -: 3];
    assign w_immA   = instr[2*IMM_W-1 -: IMM_W];
    assign w_immB   = instr[IMM_W-1:0];
    assign w_a      = {{(WIDTH-IMM_W){w_immA[IMM_W-1]}}, w_immA};
    assign w_b      = {{(WIDTH-IMM_W){w_immB[IMM_W-1]}}, w_immB};
    assign w_accept = instr_valid && instr_ready;

    // The multiplicand is pre-shifted and the multiplier shifted down so each
    // iteration only looks at bit 0; the sign bit carries negative weight.
    assign w_lastBit = (r_cnt == CNT_W'(IMM_W - 1));
    assign w_pStep   = r_b[0] ? r_aSh : '0;
    assign w_pNext   = w_lastBit ? (r_p - w_pStep) : (r_p + w_pStep);

    always_comb begin
        w_x   = w_a;
        w_y   = w_b;
        w_sub = 1'b0;
        if (r_state == MUL) begin
            w_x = r_acc;
            w_y = w_pNext;
        end else begin
            case (w_funct)
                F_SUB:    w_sub = 1'b1;
                F_ADDACC: w_y   = r_acc;
                F_SUBACC: begin
                    w_y   = r_acc;
                    w_sub = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // On overflow the true result carries the sign of w_x, which picks the clamp.
    assign w_sum   = w_sub ? (w_x - w_y) : (w_x + w_y);
    assign w_ovf   = (w_x[WIDTH-1] == (w_y[WIDTH-1] ^ w_sub)) &&
                     (w_sum[WIDTH-1] != w_x[WIDTH-1]);
    assign w_final = ((SATURATE != 0) && w_ovf) ?
                     (w_x[WIDTH-1] ? MIN_NEG : MAX_POS) : w_sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: if (w_accept && (w_funct == F_MUL || w_funct == F_MAC)) w_stateNext = MUL;
            MUL:  if (w_lastBit) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_aSh   <= '0;
            r_b     <= '0;
            r_isMac <= 1'b0;
            r_cnt   <= '0;
            r_p     <= '0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (w_accept) begin
                    case (w_funct)
                        F_ADD, F_SUB, F_ADDACC, F_SUBACC: begin
                            r_acc   <= w_final;
                            r_ovf   <= r_ovf | w_ovf;
                            r_valid <= 1'b1;
                        end
                        F_MUL, F_MAC: begin
                            r_aSh   <= w_a;
                            r_b     <= w_immB;
                            r_isMac <= w_funct[0];
                            r_p     <= '0;
                            r_cnt   <= '0;
                        end
                        F_CLRF: r_ovf <= 1'b0;
                        default: ;
                    endcase
                end
            end else begin
                r_p   <= w_pNext;
                r_aSh <= r_aSh << 1;
                r_b   <= r_b >> 1;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_lastBit) begin
                    r_valid <= 1'b1;
                    if (r_isMac) begin
                        r_acc <= w_final;
                        r_ovf <= r_ovf | w_ovf;
                    end else begin
                        r_acc <= w_pNext;
                    end
                end
            end
        end
    end

    assign instr_ready  = (r_state == IDLE) && reset_n;
    assign busy         = (r_state == MUL);
    assign result       = r_acc;
    assign result_valid = r_valid;
    assign overflow     = r_ovf;

endmodule

// File: tb/tb_calc_accum_core.sv
// Scoreboard bench: two cores (wrap and saturate, WIDTH=16, IMM_W=8) share one
// instruction stream and are checked against an integer reference model.
module tb_calc_accum_core;

    localparam int W   = 16;
    localparam int IMM = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              instr_valid = 1'b0;
    logic [2+2*IMM:0]  instr = '0;
    logic              ready0, ready1, rv0, rv1, ovf0, ovf1, busy0, busy1;
    logic [W-1:0]      res0, res1;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   mAcc[2];
    bit   mOvf[2];

    always #5 clk = ~clk;

    calc_accum_core #(.WIDTH(W), .IMM_W(IMM), .SATURATE(0)) dutWrap (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(ready0),
        .instr(instr), .result(res0), .result_valid(rv0), .overflow(ovf0), .busy(busy0)
    );

    calc_accum_core #(.WIDTH(W), .IMM_W(IMM), .SATURATE(1)) dutSat (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(ready1),
        .instr(instr), .result(res1), .result_valid(rv1), .overflow(ovf1), .busy(busy1)
    );

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: exact integer arithmetic, then range check, wrap or clamp.
    task automatic modelStep(input logic [2:0] f, input int a, input int b, input bit sat,
                             input int accIn, input bit ovfIn,
                             output int accOut, output bit ovfOut, output bit emits);
        longint t;
        logic [15:0] w16;
        t = 0;
        emits = 1'b1;
        accOut = accIn;
        ovfOut = ovfIn;
        case (f)
            3'd0: t = longint'(a) + longint'(b);
            3'd1: t = longint'(a) - longint'(b);
            3'd2: t = longint'(a) + longint'(accIn);
            3'd3: t = longint'(a) - longint'(accIn);
            3'd4: t = longint'(a) * longint'(b);
            3'd5: t = longint'(accIn) + longint'(a) * longint'(b);
            3'd6: begin ovfOut = 1'b0; emits = 1'b0; end
            default: emits = 1'b0;
        endcase
        if (emits) begin
            if (t > 32767 || t < -32768) begin
                ovfOut = 1'b1;
                if (sat) begin
                    accOut = (t > 0) ? 32767 : -32768;
                end else begin
                    w16 = t[15:0];
                    accOut = int'($signed(w16));
                end
            end else begin
                accOut = int'(t);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rv0 === 1'b1) begin
            if (q0.size() == 0) begin
                checkVal("unexpectedPulseWrap", 32'(rv0), 32'd0);
            end else begin
                e = q0.pop_front();
                checkVal("resultWrap", 32'(res0), 32'(e.res));
                checkVal("overflowWrap", 32'(ovf0), 32'(e.ovf));
            end
        end
        if (rv1 === 1'b1) begin
            if (q1.size() == 0) begin
                checkVal("unexpectedPulseSat", 32'(rv1), 32'd0);
            end else begin
                e = q1.pop_front();
                checkVal("resultSat", 32'(res1), 32'(e.res));
                checkVal("overflowSat", 32'(ovf1), 32'(e.ovf));
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] f, input int a, input int b, input bit hold,
                                 output int waited);
        exp_t e;
        int   accN;
        bit   ovfN, emits;
        logic [18:0] word;
        word = {f, a[7:0], b[7:0]};
        waited = 0;
        @(negedge clk);
        if (hold) begin
            instr = word;
            instr_valid = 1'b1;
        end else begin
            instr_valid = 1'b0;
        end
        while (ready0 !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) checkVal("readyTimeout", 32'(ready0), 32'd1);
        instr = word;
        instr_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            modelStep(f, a, b, (k == 1), mAcc[k], mOvf[k], accN, ovfN, emits);
            mAcc[k] = accN;
            mOvf[k] = ovfN;
            e.res = accN[15:0];
            e.ovf = ovfN;
            if (emits) begin
                if (k == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
        @(posedge clk);
    endtask

    task automatic endBurst();
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy0 === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkVal("idleTimeout", 32'(busy0), 32'd0);
    endtask

    task automatic checkOutput(input string tag);
        logic [15:0] e0, e1;
        e0 = mAcc[0][15:0];
        e1 = mAcc[1][15:0];
        checkVal({tag, "AccWrap"}, 32'(res0), 32'(e0));
        checkVal({tag, "AccSat"}, 32'(res1), 32'(e1));
        checkVal({tag, "OvfWrap"}, 32'(ovf0), 32'(mOvf[0]));
        checkVal({tag, "OvfSat"}, 32'(ovf1), 32'(mOvf[1]));
    endtask

    task automatic checkMulTiming(input string tag);
        int n = 0;
        bit readyBad = 1'b0;
        bit mirrorBad = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        while (busy0 === 1'b1 && n < 50) begin
            if (ready0 !== 1'b0) readyBad = 1'b1;
            if (busy1 !== busy0) mirrorBad = 1'b1;
            n++;
            @(negedge clk);
        end
        checkVal({tag, "BusyCycles"}, 32'(n), 32'(IMM));
        checkVal({tag, "ReadyLow"}, 32'(readyBad), 32'd0);
        checkVal({tag, "BusyMirror"}, 32'(mirrorBad), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int a, b;
        logic [2:0] f;
        bit hold;
        mAcc[0] = 0; mAcc[1] = 0;
        mOvf[0] = 1'b0; mOvf[1] = 1'b0;

        #1;
        checkVal("resetReady", 32'(ready0), 32'd0);
        checkVal("resetResult", 32'(res0), 32'd0);
        checkVal("resetValid", 32'(rv0), 32'd0);
        checkVal("resetOverflow", 32'(ovf0), 32'd0);
        checkVal("resetBusy", 32'(busy0), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkVal("readyAfterRelease", 32'(ready0), 32'd1);

        $display("[TB] directed: ADD / ADDACC burst");
        applyStimulus(3'd0, 5, -3, 1'b0, w);
        endBurst();
        checkOutput("add");
        checkVal("addIsTwo", 32'(res0), 32'd2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'd2, 100, 0, 1'b0, w);
            if (i > 0) checkVal("b2bNoStall", 32'(w), 32'd0);
        end
        endBurst();
        checkOutput("addacc");
        checkVal("addaccIs302", 32'(res0), 32'd302);

        $display("[TB] directed: MUL / MAC overflow and saturation");
        applyStimulus(3'd4, 127, 127, 1'b0, w);
        checkMulTiming("mul");
        checkVal("mulValue", 32'(res0), 32'h3F01);
        applyStimulus(3'd5, 127, 127, 1'b0, w);
        checkMulTiming("mac1");
        checkVal("mac1Value", 32'(res0), 32'h7E02);
        applyStimulus(3'd5, 127, 127, 1'b0, w);
        checkMulTiming("mac2");
        checkVal("mac2Wrap", 32'(res0), 32'hBD03);
        checkVal("mac2Sat", 32'(res1), 32'h7FFF);
        checkVal("mac2Ovf", 32'(ovf0), 32'd1);
        checkOutput("mac2");
        applyStimulus(3'd6, 0, 0, 1'b0, w);
        endBurst();
        checkVal("clrfOvf", 32'(ovf0), 32'd0);
        checkVal("clrfAccKept", 32'(res0), 32'hBD03);
        checkOutput("clrf");

        $display("[TB] directed: NOP/CLRF held valid");
        applyStimulus(3'd7, 1, 2, 1'b1, w);
        applyStimulus(3'd6, 3, 4, 1'b1, w);
        checkVal("nopClrfNoStall", 32'(w), 32'd0);
        applyStimulus(3'd7, 5, 6, 1'b1, w);
        checkVal("nopNoStall", 32'(w), 32'd0);
        endBurst();
        repeat (2) @(negedge clk);
        checkOutput("nop");

        $display("[TB] directed: reset during multiply");
        applyStimulus(3'd4, 50, -60, 1'b0, w);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkVal("abortResult", 32'(res0), 32'd0);
        checkVal("abortOverflow", 32'(ovf0), 32'd0);
        checkVal("abortBusy", 32'(busy0), 32'd0);
        checkVal("abortReady", 32'(ready0), 32'd0);
        checkVal("abortSatResult", 32'(res1), 32'd0);
        q0.delete();
        q1.delete();
        mAcc[0] = 0; mAcc[1] = 0;
        mOvf[0] = 1'b0; mOvf[1] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkVal("abortReleaseReady", 32'(ready0), 32'd1);
        repeat (20) @(negedge clk);

        $display("[TB] random phase");
        for (int i = 0; i < 300; i++) begin
            f = 3'($urandom_range(0, 7));
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            hold = ($urandom_range(0, 3) == 0);
            applyStimulus(f, a, b, hold, w);
            if ((i % 25) == 24) begin
                endBurst();
                waitIdle();
                checkOutput("rand");
            end
        end
        endBurst();
        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("final");
        checkVal("drainWrap", 32'(q0.size()), 32'd0);
        checkVal("drainSat", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/calc_accum_core.md
# calc_accum_core

Parametrised accumulator calculator core, the next generation of the single-cycle add/subtract calculator datapath. It accepts packed instructions (function code plus two immediates) over a valid/ready handshake and executes add, subtract and accumulate operations in one cycle. It executes signed multiply and multiply-accumulate iteratively by shift-add. It also tracks a sticky signed-overflow flag, with optional saturation.

## Interface
Parameters:
- WIDTH, 32, accumulator/result width; must satisfy WIDTH >= 2*IMM_W
- IMM_W, 14, width of each signed immediate
- SATURATE, 0, 1 = clamp to signed max/min on overflow; 0 = wrap modulo 2^WIDTH

Ports:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  core can accept; 0 while reset_n low
- instr  in  3+2*IMM_W  funct = instr[2+2*IMM_W:2*IMM_W], immA = next IMM_W bits, immB = low IMM_W bits
- result  out  WIDTH  accumulator (ACC) value
- result_valid  out  1  one-cycle pulse: ACC just updated by an op
- overflow  out  1  sticky signed overflow
- busy  out  1  multiply in progress

## Operation
- One clock domain (clk); reset is asynchronous and active-low (reset_n).
- Accept = instr_valid && instr_ready at a rising edge.
- instr_ready = (state == IDLE) && reset_n.
- immA/immB are sign-extended to WIDTH bits (A, B) at accept.
- funct 000 ADD: ACC <= A + B
- funct 001 SUB: ACC <= A - B
- funct 010 ADDACC: ACC <= A + ACC
- funct 011 SUBACC: ACC <= A - ACC
- funct 100 MUL: ACC <= A * B, signed, iterative
- funct 101 MAC: ACC <= ACC + A * B, iterative; add uses the ACC value at accept time
- funct 110 CLRF: overflow <= 0; ACC unchanged; no result_valid
- funct 111 NOP: no state change; no result_valid
- States are IDLE and MUL.
  - Single-cycle ops complete at the accept edge.
  - MUL/MAC latch A, B and funct, clear the partial product P and counter cnt, and enter MUL.
- Each edge in MUL processes one multiplier bit b = B[cnt]:
  - cnt < IMM_W-1: P += b ? (A << cnt) : 0.
  - cnt = IMM_W-1 (sign bit): P -= b ? (A << cnt) : 0.
  - All arithmetic is modulo 2^WIDTH; cnt then increments.
- The edge processing cnt = IMM_W-1 writes ACC (P for MUL, ACC + P for MAC), pulses result_valid, and returns to IDLE.
- Overflow is set when the final add/sub of ADD/SUB/ADDACC/SUBACC/MAC has operands of equal effective sign and a result of differing sign. MUL never overflows (WIDTH >= 2*IMM_W).
  - On overflow with SATURATE = 1: ACC <= 2^(WIDTH-1)-1 if the true result is positive, else -2^(WIDTH-1).
  - overflow stays set until CLRF or reset.
- busy = (state == MUL).

## Timing
- Reset (async assert): ACC = 0, overflow = 0, result_valid = 0, busy = 0, state = IDLE, cnt = 0, P = 0. instr_ready = 0 while reset_n is low and 1 in the first cycle after release.
- Single-cycle op accepted at edge T: result and result_valid are visible after T, for exactly one cycle. Throughput is one op per cycle; back-to-back ops produce back-to-back pulses.
- MUL/MAC accepted at edge T:
  - iterations occur at edges T+1 .. T+IMM_W;
  - ACC is written and result_valid pulses after edge T+IMM_W;
  - instr_ready and busy are 0/1 from after T until edge T+IMM_W;
  - the next accept is possible at T+IMM_W+1.
- instr held with instr_valid while instr_ready = 0 is not consumed; it is accepted at the first edge with instr_ready = 1.
- result holds its value between updates.
- reset_n falling mid-MUL aborts immediately: no result_valid pulse is ever produced for the aborted op, and ACC = 0.
- Overflow updates on the same edge as ACC.

## Test plan
- Reset release, then ADD A=5, B=-3 → result=2, result_valid high 1 cycle, overflow=0.
- ADDACC A=100 ×3 back-to-back from ACC=2 → results 102, 202, 302, result_valid high 3 consecutive cycles, instr_ready stays 1.
- MUL A=-8191, B=8191 (WIDTH=32, IMM_W=14) → instr_ready low 14 cycles, then result=0xFC003FFF, result_valid 1 cycle, busy mirrors.
- WIDTH=16, IMM_W=8, SATURATE=0: MUL 127×127 → 0x3F01; MAC 127,127 → 0x7E02; MAC 127,127 → 0xBD03 with overflow=1; CLRF → overflow=0, ACC unchanged. Same sequence with SATURATE=1 → last result 0x7FFF.
- Assert reset_n low during MUL iteration 5 → result=0, overflow=0, busy=0 immediately; after release instr_ready=1 and no result_valid pulse occurs.
- NOP and CLRF with instr_valid held continuously → accepted one per cycle, no result_valid, ACC unchanged.
